// File: rtl/pipeline_memreq_if.sv
// ----------------------------------------------------------------------------
// pipeline_memreq_if
//   Data-cache request/response bundle between the MEM stage and the dcache.
//   master : MEM stage (drives the request, receives hit and load data)
//   slave  : dcache    (receives the request, drives hit and load data)
// Signals
//   dmemREN    master->slave  1   read request
//   dmemWEN    master->slave  1   write request
//   dmemaddr   master->slave  DW  byte address
//   dmemstore  master->slave  DW  write data
//   dhit       slave->master  1   access complete this cycle
//   dmemload   slave->master  DW  read data, valid with dhit
// ----------------------------------------------------------------------------
interface pipeline_memreq_if #(
  parameter int DW = 32
);
  logic          dmemREN;
  logic          dmemWEN;
  logic [DW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore;
  logic          dhit;
  logic [DW-1:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/pipeline_memreq.sv
// ----------------------------------------------------------------------------
// pipeline_memreq
//   MEM-stage consumer of the EX/MEM latch. Converts the latched load/store
//   request into a held dcache request, stalls the pipe until dhit, captures
//   load data for MEM/WB and issues at most one cache transaction per MEM
//   instruction. Owns the sticky halt and timeout flags.
// Parameters
//   DW       address/data width
//   TIMEOUT  BUSY cycles without dhit before timeout_err sets
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   dmemREN_l/dmemWEN_l  latched load / store request
//   porto_l, rdat2_l     latched byte address / store data
//   hlt_l                latched halt
//   advance              MEM instruction leaves this cycle
//   flush                squash the current MEM instruction
//   dbus (master)        dcache request/response bundle
//   mem_stall            hold IF..EX/MEM latches
//   ldata, ldata_vld     captured load data and its valid
//   halt, timeout_err    sticky status flags
// ----------------------------------------------------------------------------
module pipeline_memreq #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN_l,
  input  logic              dmemWEN_l,
  input  logic [DW-1:0]     porto_l,
  input  logic [DW-1:0]     rdat2_l,
  input  logic              hlt_l,
  input  logic              advance,
  input  logic              flush,
  pipeline_memreq_if.master dbus,
  output logic              mem_stall,
  output logic [DW-1:0]     ldata,
  output logic              ldata_vld,
  output logic              halt,
  output logic              timeout_err
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic          sq;
  logic          wr_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] store_q;

  logic          acc;
  logic          wr;
  logic          go;
  logic          squash;
  logic          start_busy;
  logic          idle_hit_load;
  logic          busy_hit_load;
  logic          ren;
  logic          wen;
  logic          stall;
  logic [DW-1:0] addr_c;
  logic [DW-1:0] store_c;

  // Miss-cycle counter holds at TIMEOUT so it never wraps back under the limit.
  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign acc    = dmemREN_l | dmemWEN_l;
  assign wr     = dmemWEN_l;               // store wins when both are latched
  assign go     = ~hlt_l & ~flush;
  // A flush landing on the dhit cycle squashes just like an earlier one.
  assign squash = sq | flush;

  assign start_busy    = (state_q == IDLE) & go & acc & ~dbus.dhit;
  assign idle_hit_load = (state_q == IDLE) & go & acc & ~wr & dbus.dhit;
  assign busy_hit_load = (state_q == BUSY) & dbus.dhit & ~wr_q & ~squash;

  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    wen     = 1'b0;
    stall   = 1'b0;
    addr_c  = porto_l;
    store_c = rdat2_l;
    case (state_q)
      IDLE: begin
        ren   = acc & ~wr & go;
        wen   = wr & go;
        stall = acc & go & ~dbus.dhit;
        if (flush)              state_d = IDLE;
        else if (hlt_l)         state_d = HALT;
        else if (acc && dbus.dhit) state_d = advance ? IDLE : DONE;
        else if (acc)           state_d = BUSY;
      end
      BUSY: begin
        // Request replays the captured copy so latch glitches cannot leak out.
        ren     = ~wr_q;
        wen     = wr_q;
        addr_c  = addr_q;
        store_c = store_q;
        stall   = ~dbus.dhit;
        if (dbus.dhit) state_d = (squash | advance) ? IDLE : DONE;
      end
      DONE: begin
        if (advance | flush) state_d = IDLE;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Requests and stall are gated by nRST so they drop the moment reset asserts.
  assign dbus.dmemREN   = ren & nRST;
  assign dbus.dmemWEN   = wen & nRST;
  assign dbus.dmemaddr  = addr_c;
  assign dbus.dmemstore = store_c;
  assign mem_stall      = stall & nRST;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt         <= '0;
      sq          <= 1'b0;
      wr_q        <= 1'b0;
      ldata_vld   <= 1'b0;
      halt        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          ldata_vld <= idle_hit_load;
          if (!flush && hlt_l) halt <= 1'b1;
          if (start_busy) begin
            wr_q <= wr;
            cnt  <= '0;
            sq   <= 1'b0;
          end
        end
        BUSY: begin
          if (flush) sq <= 1'b1;
          if (dbus.dhit) begin
            ldata_vld <= busy_hit_load;
            sq        <= 1'b0;
          end else begin
            cnt <= cnt_sat_inc(cnt);
            if (cnt == CNT_LAST) timeout_err <= 1'b1;
          end
        end
        DONE: begin
          if (advance | flush) ldata_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q  <= '0;
      store_q <= '0;
      ldata   <= '0;
    end else begin
      if (start_busy) begin
        addr_q  <= porto_l;
        store_q <= rdat2_l;
      end
      if (idle_hit_load | busy_hit_load) ldata <= dbus.dmemload;
    end
  end

endmodule

// File: tb/tb_pipeline_memreq.sv
// ----------------------------------------------------------------------------
// tb_pipeline_memreq
//   Bench for pipeline_memreq. Expected behaviour of each memory instruction
//   is derived from its transaction description (kind, address, data, miss
//   latency, when it advances) rather than from the design's state machine.
// ----------------------------------------------------------------------------
module tb_pipeline_memreq;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          dmemREN_l;
  logic          dmemWEN_l;
  logic [DW-1:0] porto_l;
  logic [DW-1:0] rdat2_l;
  logic          hlt_l;
  logic          advance;
  logic          flush;
  logic          mem_stall;
  logic [DW-1:0] ldata;
  logic          ldata_vld;
  logic          halt;
  logic          timeout_err;

  pipeline_memreq_if #(.DW(DW)) dbus ();

  pipeline_memreq #(.DW(DW), .TIMEOUT(TMO)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .dmemREN_l   (dmemREN_l),
    .dmemWEN_l   (dmemWEN_l),
    .porto_l     (porto_l),
    .rdat2_l     (rdat2_l),
    .hlt_l       (hlt_l),
    .advance     (advance),
    .flush       (flush),
    .dbus        (dbus),
    .mem_stall   (mem_stall),
    .ldata       (ldata),
    .ldata_vld   (ldata_vld),
    .halt        (halt),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  logic        to_exp;
  logic [31:0] last_ld;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    dmemREN_l     = 1'b0;
    dmemWEN_l     = 1'b0;
    hlt_l         = 1'b0;
    advance       = 1'b0;
    flush         = 1'b0;
    porto_l       = $urandom;
    rdat2_l       = $urandom;
    dbus.dhit     = 1'b0;
    dbus.dmemload = $urandom;
  endtask

  // One memory instruction: lat miss cycles before dhit, optional DONE dwell.
  task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] ld, input int lat, input bit adv_hit, input int done_cyc);
    int reqs = 0;
    for (int k = 0; k <= lat; k++) begin
      dmemREN_l     = ~is_wr;
      dmemWEN_l     = is_wr;
      porto_l       = (k == 0) ? addr : $urandom;
      rdat2_l       = (k == 0) ? data : $urandom;
      hlt_l         = 1'b0;
      flush         = 1'b0;
      dbus.dhit     = (k == lat);
      dbus.dmemload = (k == lat) ? ld : $urandom;
      advance       = (k == lat) ? adv_hit : 1'b0;
      #2;
      chk("req_kind", 32'({dbus.dmemREN, dbus.dmemWEN}), is_wr ? 32'd1 : 32'd2);
      chk("addr", dbus.dmemaddr, addr);
      if (is_wr) chk("store", dbus.dmemstore, data);
      chk("stall", 32'(mem_stall), 32'(k < lat));
      if (dbus.dmemREN | dbus.dmemWEN) reqs++;
      tick();
      if (k >= TMO && k < lat) to_exp = 1'b1;
      chk("timeout", 32'(timeout_err), 32'(to_exp));
    end
    if (!is_wr) last_ld = ld;
    chk("ldata_vld_hit", 32'(ldata_vld), 32'(!is_wr));
    chk("ldata_hit", ldata, last_ld);
    if (!adv_hit) begin
      for (int d = 0; d <= done_cyc; d++) begin
        porto_l   = $urandom;
        dbus.dhit = 1'($urandom_range(0, 1));
        advance   = (d == done_cyc);
        #2;
        chk("done_noreq", 32'({dbus.dmemREN, dbus.dmemWEN}), 32'd0);
        chk("done_stall", 32'(mem_stall), 32'd0);
        if (dbus.dmemREN | dbus.dmemWEN) reqs++;
        tick();
        chk("done_vld", 32'(ldata_vld), 32'((d < done_cyc) && !is_wr));
      end
    end
    chk("nreq", 32'(reqs), 32'(lat + 1));
    idle_inputs();
  endtask

  initial begin
    to_exp  = 1'b0;
    last_ld = '0;
    nRST    = 1'b0;
    idle_inputs();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ldata", ldata, 32'd0);
    chk("rst_vld", 32'(ldata_vld), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_req", 32'({dbus.dmemREN, dbus.dmemWEN}), 32'd0);
    nRST = 1'b1;
    tick();

    // zero-wait load hit with advance
    do_txn(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 0);
    // store miss of 3 cycles, address glitches while waiting, dwell in DONE
    do_txn(1'b1, 32'h0000_0100, 32'h0000_0055, 32'h0, 3, 1'b0, 2);
    // the next store issues in IDLE right after the advance
    dmemWEN_l = 1'b1; porto_l = 32'h104; rdat2_l = 32'h66; dbus.dhit = 1'b1; advance = 1'b1;
    #2;
    chk("second_wen", 32'(dbus.dmemWEN), 32'd1);
    tick();
    idle_inputs();
    // load hit, advance withheld 4 cycles: a single request
    do_txn(1'b0, 32'h0000_0200, 32'h0, 32'h1234_5678, 0, 1'b0, 4);

    // randomized instruction stream
    for (int i = 0; i < 30; i++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
             $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // flush in IDLE suppresses the request; the instruction behind it issues
    dmemREN_l = 1'b1; porto_l = 32'h300; flush = 1'b1;
    #2;
    chk("idle_flush_req", 32'(dbus.dmemREN), 32'd0);
    chk("idle_flush_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("idle_flush_vld", 32'(ldata_vld), 32'd0);
    flush = 1'b0; dbus.dhit = 1'b1; dbus.dmemload = 32'hCAFE_0001; advance = 1'b1;
    #2;
    chk("after_flush_req", 32'(dbus.dmemREN), 32'd1);
    tick();
    last_ld = 32'hCAFE_0001;
    chk("after_flush_ld", ldata, last_ld);
    idle_inputs();

    // flush while BUSY: transaction completes, load is squashed
    dmemREN_l = 1'b1; porto_l = 32'h400;
    #2;
    chk("fb_req0", 32'(dbus.dmemREN), 32'd1);
    tick();
    porto_l = 32'h999; flush = 1'b1;
    #2;
    chk("fb_req1", 32'(dbus.dmemREN), 32'd1);
    chk("fb_addr1", dbus.dmemaddr, 32'h400);
    chk("fb_stall1", 32'(mem_stall), 32'd1);
    tick();
    flush = 1'b0;
    #2;
    chk("fb_req2", 32'(dbus.dmemREN), 32'd1);
    tick();
    dbus.dhit = 1'b1; dbus.dmemload = 32'hBAD0_BAD0;
    #2;
    chk("fb_req3", 32'(dbus.dmemREN), 32'd1);
    chk("fb_stall3", 32'(mem_stall), 32'd0);
    tick();
    chk("fb_vld", 32'(ldata_vld), 32'd0);
    chk("fb_ldata", ldata, last_ld);
    dbus.dmemload = 32'h0BAD_F00D; porto_l = 32'h500;
    #2;
    chk("fb_idle_req", 32'(dbus.dmemREN), 32'd1);
    advance = 1'b1;
    tick();
    last_ld = 32'h0BAD_F00D;
    chk("fb_next_vld", 32'(ldata_vld), 32'd1);
    idle_inputs();

    // long miss: timeout after the TMO-th BUSY cycle, then normal completion
    do_txn(1'b0, 32'h0000_0600, 32'h0, 32'h7777_0000, 20, 1'b1, 0);
    repeat (2) begin
      tick();
      chk("tmo_sticky", 32'(timeout_err), 32'd1);
    end

    // asynchronous reset in the middle of a miss
    dmemREN_l = 1'b1; porto_l = 32'h700;
    tick();
    tick();
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_req", 32'({dbus.dmemREN, dbus.dmemWEN}), 32'd0);
    chk("arst_stall", 32'(mem_stall), 32'd0);
    chk("arst_ldata", ldata, 32'd0);
    chk("arst_vld", 32'(ldata_vld), 32'd0);
    chk("arst_tmo", 32'(timeout_err), 32'd0);
    chk("arst_halt", 32'(halt), 32'd0);
    to_exp  = 1'b0;
    last_ld = '0;
    idle_inputs();
    tick();
    nRST = 1'b1;
    tick();

    // halt with a pending load: no request, sticky halt
    dmemREN_l = 1'b1; hlt_l = 1'b1;
    #2;
    chk("hlt_req", 32'(dbus.dmemREN), 32'd0);
    chk("hlt_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("hlt_flag", 32'(halt), 32'd1);
    hlt_l = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dmemWEN_l = 1'(i & 1);
      #2;
      chk("hlt_absorb_req", 32'({dbus.dmemREN, dbus.dmemWEN}), 32'd0);
      chk("hlt_absorb_stall", 32'(mem_stall), 32'd0);
      tick();
      chk("hlt_sticky", 32'(halt), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
